fib_sink: RTL and testbench
===========================

# fib_sink

Clocked consumer for the asynchronous Fibonacci generator's `link_intf` output. It requests terms via `next`, and synchronises the producer's request into the `clk` domain. It captures the bundled data, returns the acknowledge, and checks each term against the Fibonacci recurrence. It sits directly downstream of `fib` and is the boundary between the self-timed datapath and the clocked test/status logic.

## Interface
- `ENC`, default "TP": link/`next` encoding. "TP" means two-phase, one transition per event. "FP" means four-phase, return-to-zero.
- `WIDTH`, default 32: data width; must match the producer.
- `SYNC_STAGES`, default 2: flops in the request synchroniser, ≥2.
- `N_TERMS`, default 48: terms consumed per run.
- `CNT_W`, default 16: counter width; must hold `N_TERMS`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a run.
- `in`  `link_intf.in`  —  `in.req` (async), `in.data[WIDTH]` (bundled, stable while req pending), `in.ack` (driven here, from a flop).
- `next`  out  1  term request to producer, encoded per `ENC`, from a flop.
- `busy`  out  1  run in progress.
- `done`  out  1  set when `N_TERMS` consumed; cleared by `start`.
- `count`  out  `CNT_W`  terms consumed this run.
- `last_value`  out  `WIDTH`  most recent captured term.
- `err`  out  1  sticky mismatch flag.
- `err_idx`  out  `CNT_W`  index of first mismatching term.
- `err_value`  out  `WIDTH`  first mismatching received value.

## Operation
- Reset: all outputs 0, including `in.ack`, `next` and the TP phase registers. Reset clears the FSM to IDLE regardless of any pending handshake. The producer must be reset in the same window.
- FSM states: IDLE, REQ, WAIT, CAPTURE, ACK, RTZ, CHECK.
- IDLE: when `start` is seen, clear `count`, `done`, `err`, `err_idx`, `err_value` and the expectation registers, set `busy` = 1, and go to REQ. `start` while `busy` is ignored.
- REQ: TP toggles `next`; FP sets `next` = 1. Go to WAIT.
- WAIT: hold until the synchronised request event arrives. TP: synchronised `in.req` ≠ local phase. FP: synchronised `in.req` = 1. Then go to CAPTURE. No timeout.
- CAPTURE: register `in.data` into `last_value`. FP deasserts `next`. Go to ACK.
- ACK: TP toggles `in.ack` to equal the req phase; FP sets `in.ack` = 1. Then go to CHECK (TP) or RTZ (FP).
- RTZ (FP only): wait for synchronised `in.req` = 0, then set `in.ack` = 0 and go to CHECK.
- CHECK:
  - Compare `last_value` with the expected term: index 0 expects 0, index 1 expects 1, and index k expects (exp[k−1] + exp[k−2]) mod 2^WIDTH.
  - Arithmetic is WIDTH-bit modular; wrap-around is not an error.
  - The expectation is regenerated internally, not taken from received data, so a single corrupt term flags once and does not cascade.
  - On the first mismatch, latch `err` = 1, `err_idx` = `count`, and `err_value`. Later mismatches leave all three unchanged.
  - Increment `count`. If `count` reaches `N_TERMS`: `busy` = 0, `done` = 1, go to IDLE. Otherwise go to REQ.
- A producer request arriving while not in WAIT is held pending, because the edge is retained in the synchroniser/phase compare.

## Timing
- Request-to-visible latency: `SYNC_STAGES` cycles from the `in.req` edge.
- Synchronised request to `last_value` valid: 1 cycle (CAPTURE).
- Capture to `in.ack` edge: 1 cycle.
- CHECK result (`err`/`count`) updates 1 cycle after ACK (TP), or 1 cycle after RTZ completes (FP).
- TP steady state: `next` edge every 5 + `SYNC_STAGES` cycles plus producer delay.
- `count` increments exactly once per term. `done` rises in the same cycle as the final `count` update.
- `start` in the same cycle as `rst_n` = 0: reset wins.

## Structure
- Package `link_pkg`:
  - `enc_e` enum: TP, FP.
  - function mapping the `ENC` string to `enc_e`; elaboration error on any other string.
  - FSM state typedef.
  - constants `FIB_F0` = 0, `FIB_F1` = 1.
- Sub-module `link_sync`: `SYNC_STAGES`-deep flop chain on `in.req`, reset to 0 by `rst_n`. Reusable by other link sinks.
- Top: FSM, phase registers, capture register, expectation registers, counters.

## Test plan
- TP, WIDTH 32, N_TERMS 10, correct producer model → 0,1,1,2,3,5,8,13,21,34 captured; `count` = 10, `done` = 1, `err` = 0; exactly 10 `next` and 10 `in.ack` transitions.
- FP, same run → `in.ack` rises only after `next` falls, and falls only after `in.req` = 0; result identical to the TP case.
- Producer emits 7 instead of 8 at index 6 → `err` = 1, `err_idx` = 6, `err_value` = 7; a later bad term at index 8 leaves all three unchanged.
- WIDTH 8, N_TERMS 16 → index 14 expects 377 mod 256 = 121; no error, `done` = 1.
- Assert `rst_n` low while in WAIT with `next` pending → next cycle `next` = 0, `in.ack` = 0, `busy` = 0; after reset a new `start` runs cleanly from index 0.
- `start` pulsed mid-run and `in.req` delayed 50 cycles → second `start` ignored; FSM holds in WAIT, then completes with the correct count.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: shared types and constants for clocked sinks of the async link.
//   enc_e         - link encoding (TP two-phase, FP four-phase return-to-zero)
//   state_e       - fib_sink FSM states
//   FIB_F0/FIB_F1 - seed terms of the Fibonacci recurrence
//   enc_from_str  - maps the ENC parameter string to enc_e
//   enc_valid     - true only for the two legal ENC strings
package link_pkg;

   typedef enum logic {TP, FP} enc_e;

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_CAPTURE, S_ACK, S_RTZ, S_CHECK
   } state_e;

   localparam int FIB_F0 = 0;
   localparam int FIB_F1 = 1;

   function automatic bit enc_valid(input logic [15:0] s);
      return (s == "TP") || (s == "FP");
   endfunction

   function automatic enc_e enc_from_str(input logic [15:0] s);
      return (s == "FP") ? FP : TP;
   endfunction

endpackage

// File: rtl/link_intf.sv
// link_intf: bundled-data link from an asynchronous producer.
//   req  - producer request (async to any sink clock)
//   data - bundled data, stable while req is pending
//   ack  - sink acknowledge
// Modports: out (producer side), in (sink side).
interface link_intf #(parameter int WIDTH = 32);
   logic             req;
   logic             ack;
   logic [WIDTH-1:0] data;

   modport out (output req, output data, input ack);
   modport in  (input req, input data, output ack);
endinterface

// File: rtl/link_sync.sv
// link_sync: SYNC_STAGES-deep flop chain bringing an async link request
// into the clk domain. Reset clears the chain to 0.
//   clk   - sink clock
//   rst_n - synchronous active-low reset
//   req_i - asynchronous request
//   req_o - synchronised request (SYNC_STAGES cycles behind req_i)
module link_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   output logic req_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
   end

   assign req_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fib_sink.sv
// fib_sink: clocked consumer of the async Fibonacci producer. Requests terms
// on next, synchronises in.req, captures in.data, acknowledges, and checks
// each term against an internally regenerated Fibonacci sequence.
//   clk        - sole clock
//   rst_n      - synchronous active-low reset
//   start      - one-cycle pulse starting a run (ignored while busy)
//   in         - link_intf sink side (req/data in, ack out)
//   next       - term request to producer (TP toggle / FP level)
//   busy       - run in progress
//   done       - N_TERMS consumed; cleared by start
//   count      - terms consumed this run
//   last_value - most recently captured term
//   err        - sticky mismatch flag
//   err_idx    - index of first mismatching term
//   err_value  - first mismatching received value
module fib_sink import link_pkg::*; #(
   parameter logic [15:0] ENC         = "TP",
   parameter int          WIDTH       = 32,
   parameter int          SYNC_STAGES = 2,
   parameter int          N_TERMS     = 48,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   link_intf.in             in,
   output logic             next,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] last_value,
   output logic             err,
   output logic [CNT_W-1:0] err_idx,
   output logic [WIDTH-1:0] err_value
);

   if (!enc_valid(ENC) || SYNC_STAGES < 2) begin : g_param_err
      $error("fib_sink: ENC must be \"TP\" or \"FP\" and SYNC_STAGES >= 2");
   end

   localparam bit               IS_TP  = (enc_from_str(ENC) == TP);
   localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_TERMS - 1);
   localparam logic [WIDTH-1:0] F0     = WIDTH'(FIB_F0);
   localparam logic [WIDTH-1:0] F1     = WIDTH'(FIB_F1);

   state_e           state_q;
   logic             next_q, ack_q, busy_q, done_q, err_q;
   logic [CNT_W-1:0] count_q, err_idx_q;
   logic [WIDTH-1:0] last_q, err_val_q;
   // exp_cur_q is the term expected at index count_q, exp_nxt_q the one after.
   logic [WIDTH-1:0] exp_cur_q, exp_nxt_q, exp_sum_d;
   logic             req_s, req_evt_d;

   link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (in.req),
      .req_o (req_s)
   );

   // In TP, ack_q doubles as the local phase: a new request is any
   // synchronised req level differing from the last acknowledged one.
   assign req_evt_d = IS_TP ? (req_s != ack_q) : req_s;
   assign exp_sum_d = exp_cur_q + exp_nxt_q;   // modular wrap is intended

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         next_q    <= 1'b0;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= '0;
         err_idx_q <= '0;
         last_q    <= '0;
         err_val_q <= '0;
         exp_cur_q <= F0;
         exp_nxt_q <= F1;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               count_q   <= '0;
               done_q    <= 1'b0;
               err_q     <= 1'b0;
               err_idx_q <= '0;
               err_val_q <= '0;
               exp_cur_q <= F0;
               exp_nxt_q <= F1;
               busy_q    <= 1'b1;
               state_q   <= S_REQ;
            end
            S_REQ: begin
               next_q  <= IS_TP ? ~next_q : 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: if (req_evt_d) state_q <= S_CAPTURE;
            S_CAPTURE: begin
               last_q <= in.data;
               if (!IS_TP) next_q <= 1'b0;
               state_q <= S_ACK;
            end
            S_ACK: begin
               ack_q   <= IS_TP ? req_s : 1'b1;
               state_q <= IS_TP ? S_CHECK : S_RTZ;
            end
            S_RTZ: if (!req_s) begin
               ack_q   <= 1'b0;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (last_q != exp_cur_q && !err_q) begin
                  err_q     <= 1'b1;
                  err_idx_q <= count_q;
                  err_val_q <= last_q;
               end
               exp_cur_q <= exp_nxt_q;
               exp_nxt_q <= exp_sum_d;
               count_q   <= count_q + 1'b1;
               if (count_q == N_LAST) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_REQ;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in.ack     = ack_q;
   assign next       = next_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign count      = count_q;
   assign last_value = last_q;
   assign err        = err_q;
   assign err_idx    = err_idx_q;
   assign err_value  = err_val_q;

endmodule

// File: tb/tb_fib_sink.sv
// Bench for fib_sink: a TP/WIDTH32/N10 instance and an FP/WIDTH8/N16
// instance, each driven by a producer task. Producers push the sent term
// into a queue; monitors pop and compare on every acknowledge edge.
module tb_fib_sink;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, a_start, b_start;
   link_intf #(.WIDTH(32)) a_if ();
   link_intf #(.WIDTH(8))  b_if ();

   logic        a_next, a_busy, a_done, a_err;
   logic [15:0] a_count, a_err_idx;
   logic [31:0] a_last, a_err_val;
   logic        b_next, b_busy, b_done, b_err;
   logic [15:0] b_count, b_err_idx;
   logic [7:0]  b_last, b_err_val;

   fib_sink #(.ENC("TP"), .WIDTH(32), .SYNC_STAGES(2), .N_TERMS(10), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .in(a_if), .next(a_next),
      .busy(a_busy), .done(a_done), .count(a_count), .last_value(a_last),
      .err(a_err), .err_idx(a_err_idx), .err_value(a_err_val));

   fib_sink #(.ENC("FP"), .WIDTH(8), .SYNC_STAGES(2), .N_TERMS(16), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .in(b_if), .next(b_next),
      .busy(b_busy), .done(b_done), .count(b_count), .last_value(b_last),
      .err(b_err), .err_idx(b_err_idx), .err_value(b_err_val));

   int errors = 0;
   int checks = 0;

   logic [31:0] a_q [$];
   logic [31:0] b_q [$];

   // Hand-computed Fibonacci tables.
   logic [31:0] fib32 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
   logic [7:0]  fib8  [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for DUT", name);
   endtask

   // TP producer: one term per next transition, req toggles per term.
   task automatic a_term(input logic [31:0] v, input int dly);
      int t;
      t = 0;
      while (a_next == a_if.req && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin tmo("a_next_wait"); return; end
      repeat (dly) @(negedge clk);
      a_if.data = v;
      a_q.push_back(v);
      a_if.req = ~a_if.req;
      t = 0;
      while (a_if.ack != a_if.req && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) tmo("a_ack_wait");
   endtask

   // FP producer: full return-to-zero handshake per term.
   task automatic b_term(input logic [7:0] v, input int dly);
      int t;
      t = 0;
      while (!b_next && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin tmo("b_next_wait"); return; end
      repeat (dly) @(negedge clk);
      b_if.data = v;
      b_q.push_back({24'b0, v});
      b_if.req = 1'b1;
      t = 0;
      while (!b_if.ack && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin tmo("b_ack_rise_wait"); return; end
      b_if.req = 1'b0;
      t = 0;
      while (b_if.ack && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) tmo("b_ack_fall_wait");
   endtask

   task automatic pulse_a_start();
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
   endtask

   task automatic pulse_b_start();
      b_start = 1'b1; @(negedge clk); b_start = 1'b0;
   endtask

   // Monitor A: every ack transition is one captured term.
   logic a_ack_p = 1'b0, a_next_p = 1'b0;
   int   a_next_ev = 0, a_ack_ev = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_next != a_next_p) a_next_ev++;
         if (a_if.ack != a_ack_p) begin
            a_ack_ev++;
            if (a_q.size() == 0) tmo("a_capture_no_term_queued");
            else chk("a_capture", a_last, a_q.pop_front());
         end
      end
      a_ack_p  = a_if.ack;
      a_next_p = a_next;
   end

   // Monitor B: ack rise is a capture; checks four-phase ordering too.
   logic b_ack_p = 1'b0;
   int   b_rise = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (b_if.ack && !b_ack_p) begin
            b_rise++;
            chk("b_ack_rise_after_next_fall", 32'(b_next), 32'd0);
            if (b_q.size() == 0) tmo("b_capture_no_term_queued");
            else chk("b_capture", 32'(b_last), b_q.pop_front());
         end
         if (!b_if.ack && b_ack_p) chk("b_ack_fall_after_req_low", 32'(b_if.req), 32'd0);
      end
      b_ack_p = b_if.ack;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bad [10];
      int t;
      rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
      a_if.req = 1'b0; a_if.data = '0; b_if.req = 1'b0; b_if.data = '0;
      repeat (3) @(negedge clk);

      chk("rst_a_next",  32'(a_next),   0);
      chk("rst_a_ack",   32'(a_if.ack), 0);
      chk("rst_a_busy",  32'(a_busy),   0);
      chk("rst_a_done",  32'(a_done),   0);
      chk("rst_a_count", 32'(a_count),  0);
      chk("rst_a_err",   32'(a_err),    0);
      chk("rst_b_next",  32'(b_next),   0);
      chk("rst_b_ack",   32'(b_if.ack), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Run 1: clean TP run.
      a_next_ev = 0; a_ack_ev = 0;
      pulse_a_start();
      for (int i = 0; i < 10; i++) a_term(fib32[i], i % 3);
      repeat (4) @(negedge clk);
      chk("a1_count",   32'(a_count), 10);
      chk("a1_done",    32'(a_done),  1);
      chk("a1_busy",    32'(a_busy),  0);
      chk("a1_err",     32'(a_err),   0);
      chk("a1_last",    a_last,       34);
      chk("a1_next_ev", a_next_ev,    10);
      chk("a1_ack_ev",  a_ack_ev,     10);

      // Run 2: bad term at index 6 (7 instead of 8), another at index 8.
      for (int i = 0; i < 10; i++) bad[i] = fib32[i];
      bad[6] = 32'd7;
      bad[8] = 32'd99;
      pulse_a_start();
      chk("a2_done_cleared",  32'(a_done),  0);
      chk("a2_count_cleared", 32'(a_count), 0);
      for (int i = 0; i < 10; i++) a_term(bad[i], 1);
      repeat (4) @(negedge clk);
      chk("a2_err",       32'(a_err),     1);
      chk("a2_err_idx",   32'(a_err_idx), 6);
      chk("a2_err_value", a_err_val,      7);
      chk("a2_count",     32'(a_count),   10);
      chk("a2_done",      32'(a_done),    1);

      // Run 3: reset while waiting on a pending request.
      pulse_a_start();
      chk("a3_err_cleared", 32'(a_err), 0);
      a_term(fib32[0], 0);
      a_term(fib32[1], 0);
      t = 0;
      while (a_next == a_if.req && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) tmo("a3_next_pending");
      repeat (3) @(negedge clk);
      chk("a3_busy_waiting", 32'(a_busy), 1);
      chk("a3_next_pending", 32'(a_next), 1);
      rst_n = 1'b0; a_if.req = 1'b0; a_if.data = '0;
      @(negedge clk);
      chk("a3_rst_next", 32'(a_next),   0);
      chk("a3_rst_ack",  32'(a_if.ack), 0);
      chk("a3_rst_busy", 32'(a_busy),   0);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_a_start();
      for (int i = 0; i < 10; i++) a_term(fib32[i], 0);
      repeat (4) @(negedge clk);
      chk("a3_count", 32'(a_count), 10);
      chk("a3_done",  32'(a_done),  1);
      chk("a3_err",   32'(a_err),   0);

      // Run 4: FP, WIDTH 8 wrap, start mid-run, one slow term.
      b_rise = 0;
      pulse_b_start();
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            pulse_b_start();
            chk("b_start_ignored_count", 32'(b_count), 5);
            chk("b_start_ignored_busy",  32'(b_busy),  1);
         end
         b_term(fib8[i], (i == 7) ? 50 : 1);
      end
      repeat (4) @(negedge clk);
      chk("b_count", 32'(b_count), 16);
      chk("b_done",  32'(b_done),  1);
      chk("b_busy",  32'(b_busy),  0);
      chk("b_err",   32'(b_err),   0);
      chk("b_last",  32'(b_last),  98);
      chk("b_rises", b_rise,       16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
